// File: rtl/mat_ops_stream_if.sv
// Request/result bundle for mat_ops_stream: operands and op select in,
// one saturated element per valid/ready handshake out, plus status.
interface mat_ops_stream_if #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3
);
  localparam int FLAT_W = DATA_W * MAX_DIM * MAX_DIM;

  logic                     start;
  logic [2:0]               op_sel;
  logic [FLAT_W-1:0]        mat_a_flat;
  logic [FLAT_W-1:0]        mat_b_flat;
  logic [DIM_W-1:0]         a_m;
  logic [DIM_W-1:0]         a_n;
  logic [DIM_W-1:0]         b_m;
  logic [DIM_W-1:0]         b_n;
  logic signed [DATA_W-1:0] scalar_k;
  logic                     busy;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [DATA_W-1:0] res_data;
  logic                     res_last;
  logic [DIM_W-1:0]         res_m;
  logic [DIM_W-1:0]         res_n;
  logic                     done;
  logic                     err;
  logic [1:0]               err_code;
  logic                     sat_flag;

  modport master (
    output start, op_sel, mat_a_flat, mat_b_flat, a_m, a_n, b_m, b_n,
           scalar_k, res_ready,
    input  busy, res_valid, res_data, res_last, res_m, res_n, done, err,
           err_code, sat_flag
  );

  modport slave (
    input  start, op_sel, mat_a_flat, mat_b_flat, a_m, a_n, b_m, b_n,
           scalar_k, res_ready,
    output busy, res_valid, res_data, res_last, res_m, res_n, done, err,
           err_code, sat_flag
  );
endinterface

// File: rtl/mat_ops_stream.sv
// Streaming matrix unit: transpose/add/scalar/multiply, one element per handshake.
// Define MAT_OPS_STREAM_CONV_EN to add valid 2-D convolution as op 100.
module mat_ops_stream #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  mat_ops_stream_if.slave   bus
);
  localparam int NUM   = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(NUM);
  localparam int ACC_W = 2 * DATA_W + $clog2(MAX_DIM) + 1;

  localparam logic [2:0] OP_TRN = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SCL = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
`ifdef MAT_OPS_STREAM_CONV_EN
  localparam logic [2:0] OP_CNV = 3'b100;
`endif

  localparam logic [DIM_W-1:0]         MAXD  = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0]         ONE   = DIM_W'(1);
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  A_MAX = {{(ACC_W-DATA_W){1'b0}}, D_MAX};
  localparam logic signed [ACC_W-1:0]  A_MIN = {{(ACC_W-DATA_W){1'b1}}, D_MIN};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT, S_FIN} state_t;

  state_t                   r_state;
  logic signed [DATA_W-1:0] r_a [NUM];
  logic signed [DATA_W-1:0] r_b [NUM];
  logic [DIM_W-1:0]         r_am, r_an, r_bn;
`ifdef MAT_OPS_STREAM_CONV_EN
  logic [DIM_W-1:0]         r_bm;
`endif
  logic [2:0]               r_op;
  logic signed [DATA_W-1:0] r_k;
  logic [DIM_W-1:0]         r_row, r_col, r_ki, r_kj;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_busy, r_valid, r_last, r_done, r_err, r_sat;
  logic signed [DATA_W-1:0] r_data;
  logic [DIM_W-1:0]         r_res_m, r_res_n;
  logic [1:0]               r_err_code;

  logic signed [DATA_W-1:0] w_a_in [NUM];
  logic signed [DATA_W-1:0] w_b_in [NUM];

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
      assign w_a_in[gi] = bus.mat_a_flat[gi*DATA_W +: DATA_W];
      assign w_b_in[gi] = bus.mat_b_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  function automatic logic [IDX_W-1:0] f_idx(input logic [DIM_W-1:0] row,
                                             input logic [DIM_W-1:0] n,
                                             input logic [DIM_W-1:0] col);
    return IDX_W'(row) * IDX_W'(n) + IDX_W'(col);
  endfunction

  // Request validation, evaluated against the live inputs while idle
  logic             w_a_bad, w_b_bad, w_uses_b, w_op_ok, w_mism;
  logic [DIM_W-1:0] w_res_m_in, w_res_n_in;
  logic [1:0]       w_chk_code;

  always_comb begin
    w_a_bad    = (bus.a_m == '0) || (bus.a_m > MAXD) || (bus.a_n == '0) || (bus.a_n > MAXD);
    w_b_bad    = (bus.b_m == '0) || (bus.b_m > MAXD) || (bus.b_n == '0) || (bus.b_n > MAXD);
    w_uses_b   = 1'b0;
    w_op_ok    = (bus.op_sel <= OP_MUL);
    w_mism     = 1'b0;
    w_res_m_in = bus.a_m;
    w_res_n_in = bus.a_n;
    case (bus.op_sel)
      OP_TRN: begin
        w_res_m_in = bus.a_n;
        w_res_n_in = bus.a_m;
      end
      OP_ADD: begin
        w_uses_b = 1'b1;
        w_mism   = (bus.a_m != bus.b_m) || (bus.a_n != bus.b_n);
      end
      OP_MUL: begin
        w_uses_b   = 1'b1;
        w_mism     = (bus.a_n != bus.b_m);
        w_res_n_in = bus.b_n;
      end
`ifdef MAT_OPS_STREAM_CONV_EN
      OP_CNV: begin
        w_uses_b   = 1'b1;
        w_op_ok    = 1'b1;
        w_mism     = (bus.b_m > bus.a_m) || (bus.b_n > bus.a_n);
        w_res_m_in = bus.a_m - bus.b_m + ONE;
        w_res_n_in = bus.a_n - bus.b_n + ONE;
      end
`endif
      default: ;
    endcase
    if (w_a_bad || (w_uses_b && w_b_bad)) w_chk_code = 2'd1;
    else if (!w_op_ok)                    w_chk_code = 2'd3;
    else if (w_mism)                      w_chk_code = 2'd2;
    else                                  w_chk_code = 2'd0;
  end

  // Operand addressing for the element (r_row, r_col) and MAC step (r_ki, r_kj)
  logic [IDX_W-1:0] w_a_idx, w_b_idx;
  logic [DIM_W-1:0] w_ki_lim, w_kj_lim;
  logic             w_mac_op;

  always_comb begin
    w_a_idx  = f_idx(r_row, r_an, r_col);
    w_b_idx  = f_idx(r_row, r_bn, r_col);
    w_ki_lim = ONE;
    w_kj_lim = r_an;
    w_mac_op = 1'b0;
    case (r_op)
      OP_TRN: w_a_idx = f_idx(r_col, r_an, r_row);
      OP_MUL: begin
        w_mac_op = 1'b1;
        w_a_idx  = f_idx(r_row, r_an, r_kj);
        w_b_idx  = f_idx(r_kj, r_bn, r_col);
      end
`ifdef MAT_OPS_STREAM_CONV_EN
      OP_CNV: begin
        w_mac_op = 1'b1;
        w_ki_lim = r_bm;
        w_kj_lim = r_bn;
        w_a_idx  = f_idx(r_row + r_ki, r_an, r_col + r_kj);
        w_b_idx  = f_idx(r_ki, r_bn, r_kj);
      end
`endif
      default: ;
    endcase
  end

  logic signed [ACC_W-1:0]  w_a_ext, w_b_ext, w_k_ext, w_prod, w_elem, w_val;
  logic                     w_mac_last, w_kj_wrap, w_elem_last, w_hi, w_lo;
  logic signed [DATA_W-1:0] w_sat_data;

  always_comb begin
    w_a_ext = {{(ACC_W-DATA_W){r_a[w_a_idx][DATA_W-1]}}, r_a[w_a_idx]};
    w_b_ext = {{(ACC_W-DATA_W){r_b[w_b_idx][DATA_W-1]}}, r_b[w_b_idx]};
    w_k_ext = {{(ACC_W-DATA_W){r_k[DATA_W-1]}}, r_k};
    w_prod  = w_a_ext * w_b_ext;
    case (r_op)
      OP_ADD:  w_elem = w_a_ext + w_b_ext;
      OP_SCL:  w_elem = w_a_ext * w_k_ext;
      default: w_elem = w_a_ext;
    endcase
    w_val       = w_mac_op ? (r_acc + w_prod) : w_elem;
    w_kj_wrap   = (r_kj == w_kj_lim - ONE);
    w_mac_last  = w_kj_wrap && (r_ki == w_ki_lim - ONE);
    w_elem_last = (r_row == r_res_m - ONE) && (r_col == r_res_n - ONE);
    w_hi        = (w_val > A_MAX);
    w_lo        = (w_val < A_MIN);
    w_sat_data  = w_hi ? D_MAX : (w_lo ? D_MIN : w_val[DATA_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < NUM; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      r_am       <= '0;
      r_an       <= '0;
      r_bn       <= '0;
`ifdef MAT_OPS_STREAM_CONV_EN
      r_bm       <= '0;
`endif
      r_op       <= '0;
      r_k        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_ki       <= '0;
      r_kj       <= '0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sat      <= 1'b0;
      r_data     <= '0;
      r_res_m    <= '0;
      r_res_n    <= '0;
      r_err_code <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < NUM; i++) begin
              r_a[i] <= w_a_in[i];
              r_b[i] <= w_b_in[i];
            end
            r_am  <= bus.a_m;
            r_an  <= bus.a_n;
            r_bn  <= bus.b_n;
`ifdef MAT_OPS_STREAM_CONV_EN
            r_bm  <= bus.b_m;
`endif
            r_op  <= bus.op_sel;
            r_k   <= bus.scalar_k;
            r_row <= '0;
            r_col <= '0;
            r_ki  <= '0;
            r_kj  <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
            if (w_chk_code != 2'd0) begin
              r_err      <= 1'b1;
              r_err_code <= w_chk_code;
            end else begin
              r_err      <= 1'b0;
              r_err_code <= 2'd0;
              r_busy     <= 1'b1;
              r_res_m    <= w_res_m_in;
              r_res_n    <= w_res_n_in;
              r_state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (w_mac_op && !w_mac_last) begin
            r_acc <= w_val;
            if (w_kj_wrap) begin
              r_kj <= '0;
              r_ki <= r_ki + ONE;
            end else begin
              r_kj <= r_kj + ONE;
            end
          end else begin
            r_acc   <= '0;
            r_ki    <= '0;
            r_kj    <= '0;
            r_data  <= w_sat_data;
            r_valid <= 1'b1;
            r_last  <= w_elem_last;
            if (w_hi || w_lo) r_sat <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              if (r_col == r_res_n - ONE) begin
                r_col <= '0;
                r_row <= r_row + ONE;
              end else begin
                r_col <= r_col + ONE;
              end
              r_state <= S_CALC;
            end
          end
        end
        S_FIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.res_valid = r_valid;
  assign bus.res_data  = r_data;
  assign bus.res_last  = r_last;
  assign bus.res_m     = r_res_m;
  assign bus.res_n     = r_res_n;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.sat_flag  = r_sat;

  // r_am only feeds debug visibility of the captured request
  logic w_am_unused;
  assign w_am_unused = ^r_am;
endmodule

// File: tb/tb_mat_ops_stream.sv
// Directed bench for mat_ops_stream: hand-computed streams, error codes,
// backpressure stability, latency and mid-operation reset.
module tb_mat_ops_stream;
  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int DIM_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mat_ops_stream_if #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) bus ();

  mat_ops_stream #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int a_q[$];
  int b_q[$];
  int exp_q[$];
  int got_q[$];
  int lst_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge; returns at the negedge of cycle T+1
  task automatic launch(input logic [2:0] op, input int am, input int an,
                        input int bm, input int bn, input int k);
    @(negedge clk);
    bus.mat_a_flat = '0;
    bus.mat_b_flat = '0;
    foreach (a_q[i]) bus.mat_a_flat[i*DATA_W +: DATA_W] = DATA_W'(a_q[i]);
    foreach (b_q[i]) bus.mat_b_flat[i*DATA_W +: DATA_W] = DATA_W'(b_q[i]);
    bus.op_sel   = op;
    bus.a_m      = DIM_W'(am);
    bus.a_n      = DIM_W'(an);
    bus.b_m      = DIM_W'(bm);
    bus.b_n      = DIM_W'(bn);
    bus.scalar_k = DATA_W'(k);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.mat_a_flat = ~bus.mat_a_flat;
    bus.mat_b_flat = ~bus.mat_b_flat;
    bus.scalar_k   = ~bus.scalar_k;
    $display("start op=%0d a=%0dx%0d b=%0dx%0d k=%0d", op, am, an, bm, bn, k);
  endtask

  // Consume the stream, stalling 'stall' cycles per element, then check it
  task automatic collect(input int stall, input int exp_first);
    int cyc = 1;
    int stall_cnt = 0;
    int first = -1;
    int held_d = 0;
    int held_l = 0;
    bit finished = 0;
    got_q.delete();
    lst_q.delete();
    bus.res_ready = (stall == 0);
    for (int guard = 0; guard < 400 && !finished; guard++) begin
      if (bus.res_valid) begin
        if (first < 0) first = cyc;
        if (stall_cnt == 0) begin
          held_d = int'(bus.res_data);
          held_l = int'(bus.res_last);
        end else begin
          chk("hold_data", int'(bus.res_data), held_d);
          chk("hold_last", int'(bus.res_last), held_l);
        end
        if (stall_cnt < stall) begin
          bus.res_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.res_ready = 1'b1;
          got_q.push_back(int'(bus.res_data));
          lst_q.push_back(int'(bus.res_last));
          $display("elem %0d data=%0d last=%0d", got_q.size() - 1, bus.res_data, bus.res_last);
          stall_cnt = 0;
          if (bus.res_last) finished = 1;
        end
      end else begin
        bus.res_ready = (stall == 0);
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_end", int'(finished), 1);
    chk("done_pulse", int'(bus.done), 1);
    chk("busy_fin", int'(bus.busy), 0);
    chk("valid_fin", int'(bus.res_valid), 0);
    @(negedge clk);
    chk("done_clear", int'(bus.done), 0);
    chk("first_valid", first, exp_first);
    chk("count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        chk("elem", got_q[i], exp_q[i]);
        chk("last", lst_q[i], int'(i == exp_q.size() - 1));
      end
    end
  endtask

  task automatic expect_err(input int code);
    chk("err", int'(bus.err), 1);
    chk("err_code", int'(bus.err_code), code);
    chk("err_busy", int'(bus.busy), 0);
  endtask

  initial begin
    int act;
    int n_hs;
    bus.start = 1'b0;
    bus.op_sel = '0;
    bus.mat_a_flat = '0;
    bus.mat_b_flat = '0;
    bus.a_m = '0;
    bus.a_n = '0;
    bus.b_m = '0;
    bus.b_n = '0;
    bus.scalar_k = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.res_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_res_m", int'(bus.res_m), 0);
    chk("rst_sat", int'(bus.sat_flag), 0);
    rst = 1'b0;

    // Transpose 2x3
    a_q = '{1, 2, 3, 4, 5, 6};
    b_q = '{0};
    launch(3'b000, 2, 3, 1, 1, 0);
    chk("trn_busy", int'(bus.busy), 1);
    chk("trn_res_m", int'(bus.res_m), 3);
    chk("trn_res_n", int'(bus.res_n), 2);
    exp_q = '{1, 4, 2, 5, 3, 6};
    collect(0, 2);
    chk("trn_sat", int'(bus.sat_flag), 0);
    chk("trn_keep_m", int'(bus.res_m), 3);

    // Add with mismatched dimensions
    a_q = '{1, 2, 3, 4};
    b_q = '{1, 2, 3, 4, 5, 6};
    launch(3'b001, 2, 2, 2, 3, 0);
    expect_err(2);
    act = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy || bus.res_valid) act++;
      @(negedge clk);
    end
    chk("mism_idle", act, 0);

    // Scalar with saturation both ways
    a_q = '{100, -100};
    b_q = '{0};
    launch(3'b010, 1, 2, 1, 1, 2);
    chk("scl_err_clr", int'(bus.err), 0);
    chk("scl_busy", int'(bus.busy), 1);
    exp_q = '{127, -128};
    collect(0, 2);
    chk("scl_sat", int'(bus.sat_flag), 1);

    // Multiply 2x2 with 3-cycle backpressure per element
    a_q = '{1, 2, 3, 4};
    b_q = '{5, 6, 7, 8};
    launch(3'b011, 2, 2, 2, 2, 0);
    chk("mul_sat_clr", int'(bus.sat_flag), 0);
    exp_q = '{19, 22, 43, 50};
    collect(3, 3);

    // Convolution 3x3 by 2x2 ones
    a_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    b_q = '{1, 1, 1, 1};
    launch(3'b100, 3, 3, 2, 2, 0);
`ifdef MAT_OPS_STREAM_CONV_EN
    chk("cnv_res_m", int'(bus.res_m), 2);
    chk("cnv_res_n", int'(bus.res_n), 2);
    exp_q = '{12, 16, 24, 28};
    collect(0, 5);
`else
    expect_err(3);
`endif

    // Error code ordering
    launch(3'b101, 2, 2, 2, 2, 0);
    expect_err(3);
    launch(3'b000, 0, 2, 1, 1, 0);
    expect_err(1);
    launch(3'b111, 6, 1, 1, 1, 0);
    expect_err(1);
    launch(3'b011, 2, 3, 2, 2, 0);
    expect_err(2);

    // Reset after the second element of a saturating multiply
    a_q = '{100, 100, 1, 1};
    b_q = '{1, 1, 1, 1};
    launch(3'b011, 2, 2, 2, 2, 0);
    bus.res_ready = 1'b1;
    n_hs = 0;
    for (int guard = 0; guard < 50 && n_hs < 2; guard++) begin
      if (bus.res_valid) begin
        n_hs++;
        $display("elem %0d data=%0d last=%0d", n_hs - 1, bus.res_data, bus.res_last);
        chk("rst_mul_elem", int'(bus.res_data), 127);
      end
      @(negedge clk);
    end
    chk("rst_mul_hs", n_hs, 2);
    chk("rst_mul_sat", int'(bus.sat_flag), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.res_valid), 0);
    chk("abort_sat", int'(bus.sat_flag), 0);
    chk("abort_done", int'(bus.done), 0);

    // Fresh 1x1 operation after the abort
    a_q = '{7};
    b_q = '{0};
    launch(3'b000, 1, 1, 1, 1, 0);
    chk("one_res_m", int'(bus.res_m), 1);
    exp_q = '{7};
    collect(0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mat_ops_stream.md
Name: mat_ops_stream

Overview:
- Parametrised successor to the matrix operation unit.
- Performs transpose, add, scalar multiply, matrix multiply, and (optionally) valid 2-D convolution on signed matrices up to MAX_DIM x MAX_DIM.
- Streams results element by element over a valid/ready interface, so the display/UART path can apply backpressure.
- Sits between the matrix storage block and the result formatter.

Parameters:
- DATA_W, 8, signed element width for inputs, scalar and results.
- MAX_DIM, 5, maximum rows/columns of any operand or result.
- DIM_W, 3, width of dimension ports; must satisfy 2**DIM_W > MAX_DIM.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- op_sel  in  3  000 transpose, 001 add, 010 scalar, 011 multiply, 100 conv.
- mat_a_flat  in  DATA_W*MAX_DIM*MAX_DIM  A, packed row-major; element (r,c) at index r*a_n+c.
- mat_b_flat  in  DATA_W*MAX_DIM*MAX_DIM  B, packed the same way using b_n.
- a_m, a_n, b_m, b_n  in  DIM_W each  operand dimensions.
- scalar_k  in  DATA_W  signed scalar.
- busy  out  1  operation in progress.
- res_valid  out  1  res_data holds a result element.
- res_ready  in  1  consumer accepts the element.
- res_data  out  DATA_W  saturated signed result element.
- res_last  out  1  marks the final element; qualified by res_valid.
- res_m, res_n  out  DIM_W each  result dimensions; valid while busy and after done.
- done  out  1  one-cycle pulse after the final handshake.
- err  out  1  operation rejected; held until the next accepted start.
- err_code  out  2  1 = dim zero or >MAX_DIM, 2 = dim mismatch, 3 = illegal op.
- sat_flag  out  1  sticky: some element of this operation saturated.

Behaviour:
- Reset: all outputs 0; state IDLE; internal copies cleared. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, CALC, OUT, FIN.
- IDLE, start=1 at cycle T:
  - Operands, dimensions, op_sel and scalar_k are captured.
  - err, err_code and sat_flag clear.
  - Checks run in order (code 1, then 3, then 2).
  - On failure: at T+1 err=1 with the code, busy stays 0, state stays IDLE.
  - On success: at T+1 busy=1, res_m/res_n are set, state goes to CALC.
  - Later input changes have no effect.
- Result dimensions and checks:
  - Transpose: a_n x a_m.
  - Add: a_m x a_n; requires a_m==b_m and a_n==b_n.
  - Scalar: a_m x a_n.
  - Multiply: a_m x b_n; requires a_n==b_m.
- CALC: computes the output element at the current row-major index e.
  - Transpose / add / scalar: one cycle.
  - Multiply: a_n cycles, one MAC per cycle in accumulator width ACC_W = 2*DATA_W + clog2(MAX_DIM) + 1, signed.
  - At the end, the result is saturated to [-2**(DATA_W-1), 2**(DATA_W-1)-1] into res_data; res_valid=1; res_last = (e == last); state goes to OUT.
  - If saturation occurred, sat_flag=1.
  - Add and scalar results are also computed at ACC_W before saturation.
- OUT: res_data and res_last are held stable while res_valid=1 and res_ready=0.
  - On handshake at cycle X: res_valid=0 at X+1.
  - If not last: e++, state CALC.
  - If last: state FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE. res_m/res_n are retained.
- Latency: first res_valid at T+2 for elementwise ops, T+1+a_n for multiply.
- Throughput with res_ready held high: 2 cycles/element elementwise, a_n+1 cycles/element multiply.
- start while busy is ignored.
- A 1x1 operation produces one element with res_last=1.

Optional Feature:
- Macro: MAT_OPS_STREAM_CONV_EN.
- Defined: op 100 is a valid 2-D convolution with kernel B.
  - Result dimensions: (a_m-b_m+1) x (a_n-b_n+1).
  - Requires b_m<=a_m and b_n<=a_n, else err_code 2.
  - Each element takes b_m*b_n MAC cycles, same accumulator and saturation rules as multiply.
- Undefined: op 100 is rejected with err_code 3, and no convolution logic is synthesised.
- Op codes 101-111 are always rejected with err_code 3.

Test Plan:
- Transpose: A=2x3 [1 2 3;4 5 6], res_ready=1 -> res_m=3, res_n=2; stream 1,4,2,5,3,6; res_last on 6; done one cycle after the last handshake.
- Add mismatch: a=2x2, b=2x3 -> err=1, err_code=2 at T+1; busy never asserts; no res_valid.
- Scalar saturation: A=1x2 [100,-100], k=2 -> stream 127, -128; sat_flag=1.
- Multiply with backpressure: A=[1 2;3 4], B=[5 6;7 8]; res_ready low 3 cycles per element -> stream 19, 22, 43, 50; res_data stable while stalled; first valid at T+3.
- With MAT_OPS_STREAM_CONV_EN: A=3x3 of 1..9, B=2x2 all 1 -> 2x2 result stream 12, 16, 24, 28. Without the macro: same stimulus -> err_code=3.
- Reset mid-multiply (rst after the second element) -> next cycle busy=0, res_valid=0, sat_flag=0; a new start then runs normally.
